// File: rtl/nt_pkg.sv
// nt_pkg: types, constants and arithmetic helpers shared by the nt_ blocks.
//
// Contents:
//   NT_CMD_HOLD/INC/DEC : command codes formed as {dec, inc}. The code 2'b11 is
//                         also a hold, but it still counts as a command.
//   nt_ptr_w(ch)        : width of a round-robin pointer over ch channels.
//   nt_sat_step(...)    : saturating add/sub on a level of up to 32 bits.
//   nt_sat_clamped(...) : reports whether nt_sat_step would clamp.
package nt_pkg;

    localparam logic [1:0] NT_CMD_HOLD = 2'b00;
    localparam logic [1:0] NT_CMD_INC  = 2'b01;
    localparam logic [1:0] NT_CMD_DEC  = 2'b10;

    function automatic int nt_ptr_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // The arithmetic uses one extra bit. A result above max_val saturates high.
    // A borrow out of the subtract means the result went below zero, so it
    // saturates to 0.
    function automatic logic [31:0] nt_sat_step(input logic [31:0] cur,
                                                input logic [31:0] step,
                                                input logic [31:0] max_val,
                                                input logic        up);
        logic [32:0] wide;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, step};
            return (wide > {1'b0, max_val}) ? max_val : wide[31:0];
        end
        wide = {1'b0, cur} - {1'b0, step};
        return wide[32] ? 32'd0 : wide[31:0];
    endfunction

    function automatic logic nt_sat_clamped(input logic [31:0] cur,
                                            input logic [31:0] step,
                                            input logic [31:0] max_val,
                                            input logic        up);
        logic [32:0] wide;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, step};
            return wide > {1'b0, max_val};
        end
        wide = {1'b0, cur} - {1'b0, step};
        return wide[32];
    endfunction

endpackage

// File: rtl/nt_level_channel.sv
// nt_level_channel: one saturating level register. It handles command decode,
// saturation, and the single decay step toward the resting level.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   inc_i/dec_i : increment / decrement requests ({1,1} holds)
//   fast_i      : use FAST_STEP instead of 1
//   setval_i    : load SET_VAL; has priority over inc/dec
//   decay_i     : this channel is served by the current decay tick
//   level_o     : registered level
//   sat_o       : one-cycle clamp pulse when NT_SAT_FLAGS_EN is defined, else 0
module nt_level_channel
    import nt_pkg::*;
#(
    parameter int N           = 8,
    parameter int DEFAULT_VAL = 2,
    parameter int SET_VAL     = 0,
    parameter int FAST_STEP   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         fast_i,
    input  logic         setval_i,
    input  logic         decay_i,
    output logic [N-1:0] level_o,
    output logic         sat_o
);

    localparam logic [N-1:0] DEF  = N'(DEFAULT_VAL);
    localparam logic [N-1:0] SETV = N'(SET_VAL);
    localparam logic [31:0]  MAXV = 32'({N{1'b1}});

    logic [N-1:0] level_q, level_d;
    logic [1:0]   cmd;
    logic [31:0]  step;

    assign cmd  = {dec_i, inc_i};
    assign step = fast_i ? 32'(FAST_STEP) : 32'd1;

    // Decay applies only when the channel is completely idle. The code {1,1}
    // counts as a command, so it also blocks decay.
    always_comb begin
        level_d = level_q;
        if (setval_i) begin
            level_d = SETV;
        end else if (cmd == NT_CMD_INC || cmd == NT_CMD_DEC) begin
            level_d = N'(nt_sat_step(32'(level_q), step, MAXV, cmd == NT_CMD_INC));
        end else if (cmd == NT_CMD_HOLD && decay_i) begin
            if (level_q > DEF) begin
                level_d = level_q - N'(1);
            end else if (level_q < DEF) begin
                level_d = level_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= DEF;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

`ifdef NT_SAT_FLAGS_EN
    logic sat_q, sat_d;

    assign sat_d = !setval_i && (cmd == NT_CMD_INC || cmd == NT_CMD_DEC) &&
                   nt_sat_clamped(32'(level_q), step, MAXV, cmd == NT_CMD_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/nt_neurotransmitter_bank.sv
// nt_neurotransmitter_bank: CH independent saturating N-bit levels.
// A homeostatic scheduler uses round-robin order. On each decay tick it moves
// one channel one step back toward DEFAULT_VAL.
//
// Ports:
//   clk, rst_n                : clock and asynchronous active-low reset
//   inc, dec, fast, setval    : per-channel commands, CH bits each
//   decay_en                  : runs the prescaler; when low, the prescaler
//                               clears and the pointer freezes
//   value                     : levels; channel i is value[i*N +: N]
//   decay_ptr                 : channel served by the next decay tick
//   sat_hit                   : per-channel clamp pulses
//
// Optional feature: define NT_SAT_FLAGS_EN to build the sat_hit flag
// registers. When it is undefined, sat_hit is tied to 0.
module nt_neurotransmitter_bank
    import nt_pkg::*;
#(
    parameter int N            = 8,
    parameter int CH           = 4,
    parameter int DEFAULT_VAL  = 2,
    parameter int SET_VAL      = 0,
    parameter int FAST_STEP    = 3,
    parameter int DECAY_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH-1:0]           inc,
    input  logic [CH-1:0]           dec,
    input  logic [CH-1:0]           fast,
    input  logic [CH-1:0]           setval,
    input  logic                    decay_en,
    output logic [CH*N-1:0]         value,
    output logic [nt_ptr_w(CH)-1:0] decay_ptr,
    output logic [CH-1:0]           sat_hit
);

    localparam int PW = nt_ptr_w(CH);
    localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_PERIOD - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(CH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          tick;

    // When DECAY_PERIOD is 1, CNT_LAST is 0 and tick follows decay_en.
    assign tick = decay_en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        ptr_d = ptr_q;
        if (!decay_en || tick) begin
            cnt_d = '0;
        end
        if (tick) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign decay_ptr = ptr_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        nt_level_channel #(
            .N          (N),
            .DEFAULT_VAL(DEFAULT_VAL),
            .SET_VAL    (SET_VAL),
            .FAST_STEP  (FAST_STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc[i]),
            .dec_i   (dec[i]),
            .fast_i  (fast[i]),
            .setval_i(setval[i]),
            .decay_i (tick && (ptr_q == PW'(i))),
            .level_o (value[i*N +: N]),
            .sat_o   (sat_hit[i])
        );
    end

endmodule
